// File: rtl/four_mux_pkg.sv
// Shared constants and types for the four-source mux family.
// Holds the channel count, the select width, the FSM state enum and the one-hot decode.
package four_mux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_e;

    function automatic logic [NUM_CH-1:0] onehot(input logic [SEL_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/four_rr_sel_rr_pick.sv
// Combinational rotate-and-priority-encode.
// Returns the first set request bit at or after ptr, wrapping modulo four.
module rr_pick
    import four_mux_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  idx,
    output logic              any
);

    logic [2*NUM_CH-1:0] dbl;
    logic [NUM_CH-1:0]   rot;

    always_comb begin
        // rot[k] is the request of source (ptr + k) mod 4
        dbl = {req, req} >> ptr;
        rot = dbl[NUM_CH-1:0];
        any = |req;
        idx = ptr;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (rot[k]) begin
                idx = ptr + SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/four_rr_sel.sv
// Round-robin select generator for the 4:1 data mux.
// It holds each grant until a valid/ready transfer, a request withdrawal or the stall watchdog ends it.
module four_rr_sel
    import four_mux_pkg::*;
#(
    parameter int TIMEOUT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       ready,
    output logic [1:0] sel,
    output logic [3:0] gnt,
    output logic       valid,
    output logic       timeout_err
);

    localparam logic [7:0] TMO_LAST = (TIMEOUT > 0) ? 8'(TIMEOUT - 1) : 8'd0;

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [NUM_CH-1:0] gnt_q, gnt_d;
    logic              valid_q, valid_d;
    logic              terr_q, terr_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [7:0]        cnt_q, cnt_d;

    logic [SEL_W-1:0]  pick_ptr;
    logic [SEL_W-1:0]  pick_idx;
    logic              pick_any;
    logic              ev_release, ev_xfer, ev_tmo;

    // In GRANT the picker already sees the post-release pointer so a re-grant needs no bubble
    assign pick_ptr = (state_q == ST_GRANT) ? sel_q + 2'd1 : ptr_q;

    rr_pick u_pick (
        .req (req),
        .ptr (pick_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        gnt_d      = gnt_q;
        valid_d    = valid_q;
        terr_d     = 1'b0;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        ev_release = !req[sel_q];
        ev_xfer    = ready;
        ev_tmo     = (TIMEOUT > 0) && !ready && (cnt_q == TMO_LAST);

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_GRANT;
                    sel_d   = pick_idx;
                    gnt_d   = onehot(pick_idx);
                    valid_d = 1'b1;
                    cnt_d   = 8'd0;
                end
            end
            ST_GRANT: begin
                if (ev_release || ev_xfer || ev_tmo) begin
                    ptr_d  = sel_q + 2'd1;
                    cnt_d  = 8'd0;
                    // A withdrawal in the same cycle outranks the watchdog, so no error then
                    terr_d = ev_tmo && !ev_release;
                    if (pick_any) begin
                        sel_d   = pick_idx;
                        gnt_d   = onehot(pick_idx);
                        valid_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                        valid_d = 1'b0;
                    end
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            terr_q  <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            terr_q  <= terr_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sel         = sel_q;
    assign gnt         = gnt_q;
    assign valid       = valid_q;
    assign timeout_err = terr_q;

endmodule

// File: doc/four_rr_sel.md
# four_rr_sel

Round-robin selector that sits directly upstream of the 4:1 data mux. It arbitrates among four requesting sources and drives the mux's 2-bit `sel`, holding each selection stable until the downstream consumer accepts the muxed word through a valid/ready handshake. A watchdog reclaims a grant the consumer never accepts, so one stalled path cannot lock out the other sources.

## Interface
- `TIMEOUT`, default 0: number of consecutive stalled cycles (`valid`=1, `ready`=0) before a grant is forcibly released; 0 disables the watchdog; legal range 0..255.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `req`  input  4  level request per source; bit i = data input d(i+1) of the mux.
- `ready`  input  1  downstream accepts the current muxed word this cycle.
- `sel`  output  2  mux select; binary index of the granted source.
- `gnt`  output  4  one-hot grant, equal to `1 << sel` while `valid`=1, otherwise 0.
- `valid`  output  1  muxed word is valid this cycle.
- `timeout_err`  output  1  one-cycle pulse when the watchdog releases a grant.

## Operation
- Reset: `sel`=0, `gnt`=0, `valid`=0, `timeout_err`=0, rotation pointer `ptr`=0, stall counter=0, state IDLE.
- States: IDLE and GRANT.
- Pick function: first set bit of `req`, scanning `ptr`, `ptr`+1, … modulo 4. `any` = |`req`.
- IDLE:
  - If `any`: register `sel` = pick, `gnt` = one-hot of pick, `valid`=1; go to GRANT.
  - Otherwise stay in IDLE. `sel` holds its last value, and `gnt` and `valid` stay 0.
- GRANT ends at an edge on one of three events. Priority is release > transfer > timeout.
  - **Release:** `req[sel]`=0. The requester withdrew without a transfer.
  - **Transfer:** `ready`=1.
  - **Timeout:** `TIMEOUT`>0 and the stall counter equals `TIMEOUT`-1 with `ready`=0.
- On any ending event:
  - `ptr` = `sel`+1 modulo 4, so 3 wraps to 0.
  - Re-pick in the same edge using the new `ptr` and the current `req`. If `any`, grant the new pick with no bubble cycle. Otherwise go to IDLE with `valid`=0 and `gnt`=0.
  - Only for the timeout event, `timeout_err`=1 for the next cycle.
- Stall counter:
  - Cleared on entering GRANT and on every ending event.
  - Increments on each GRANT cycle with `ready`=0.
  - Width is 8 bits and it saturates; it is unused when `TIMEOUT`=0.
- `sel` and `gnt` never change while `valid`=1 except at an ending edge.
- `req` bits other than `req[sel]` have no effect during GRANT.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Latency: a `req` sampled at edge k drives `valid`/`sel` in the cycle after edge k.
- Throughput: one transfer per cycle with all `req` high and `ready` tied to 1, with grants rotating 0,1,2,3,0….
- Transfer cycle: `valid`=1 and `ready`=1 at the same edge. `ready` while `valid`=0 is ignored.
- A timeout fires in the cycle after the `TIMEOUT`-th consecutive stalled GRANT cycle.
- `rst` mid-grant: the next cycle shows reset values. The in-flight word is dropped and no `timeout_err` is raised.
- `rst` has priority over all events in the same cycle.

## Structure
- Shared package `four_mux_pkg`:
  - `NUM_CH`=4, `SEL_W`=2.
  - State enum {`ST_IDLE`, `ST_GRANT`}.
  - Function or constant for the one-hot decode.
- Sub-module `rr_pick`:
  - Combinational; inputs `req[3:0]`, `ptr[1:0]`; outputs `idx[1:0]`, `any`.
  - Rotate-and-priority-encode, instantiated once.
  - Reusable by later arbiters in the same family.
- Top level holds the FSM, `ptr`, the stall counter and the output registers, and instantiates the existing mux fed by `sel`.

## Test plan
- Reset then `req`=4'b0000 for 10 cycles → `valid`=0, `gnt`=0, `sel`=0, `timeout_err`=0 throughout.
- `req`=4'b1111, `ready`=1 constant → `sel` sequence 0,1,2,3,0,1, `valid`=1 every cycle from the 2nd cycle on, with no bubbles.
- `req`=4'b0101, `ready` toggling 1,0,1,0… → grants alternate 0,2,0,2. Each grant is held with `sel` stable for 2 cycles.
- `TIMEOUT`=3, `req`=4'b0011, `ready`=0:
  - Grant to 0 for 3 cycles, then `timeout_err` pulses once and the grant moves to 1.
  - After 3 further stalled cycles, `timeout_err` pulses again and the grant returns to 0.
- Grant to source 2, then `req[2]` drops with `req`=4'b1000 → next cycle `sel`=3, `valid`=1, `timeout_err`=0.
- `rst` asserted during a GRANT with `ready`=1 in the same cycle → next cycle all outputs are at reset values and the next grant follows from `ptr`=0 (`req`=4'b1111 gives `sel`=0).
